// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and sizing helpers for the mac_array block.
package mac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam int N_DEFAULT     = 6;
  localparam int WIDTH_DEFAULT = 16;

  // Result width: full signed product plus headroom for N accumulations.
  function automatic int m_width(input int n, input int width);
    return 2 * width + n - 1;
  endfunction

  // Beat counter width; a single-lane array still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(N_DEFAULT);

endpackage

// File: rtl/mac_array_if.sv
// rtl/mac_array_if.sv - operand beat stream in, per-lane results and valid pulse out.
interface mac_array_if
  import mac_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int M_WIDTH = m_width(N, WIDTH)
);
  logic                   sof;
  logic [N*WIDTH-1:0]     A;
  logic [WIDTH-1:0]       B;
  logic [N*M_WIDTH-1:0]   C;
  logic [N-1:0]           valid;

  modport master (output sof, A, B, input C, valid);
  modport slave  (input sof, A, B, output C, valid);
endinterface

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one signed multiply-accumulate lane.
// MAC_ARRAY_PIPE_EN adds a product register stage ahead of the accumulator.
module mac_lane #(
  parameter int WIDTH   = 16,
  parameter int M_WIDTH = 37
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beat,
  input  logic               seed,
  input  logic               last,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [M_WIDTH-1:0] c,
  output logic               valid
);
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] s_prod;
  logic                      s_beat;
  logic                      s_seed;
  logic                      s_last;

  assign prod = $signed(a) * $signed(b);

`ifdef MAC_ARRAY_PIPE_EN
  // Control strobes travel with the product so stalls and seeds stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prod <= '0;
      s_beat <= 1'b0;
      s_seed <= 1'b0;
      s_last <= 1'b0;
    end else begin
      s_prod <= prod;
      s_beat <= beat;
      s_seed <= seed;
      s_last <= last;
    end
  end
`else
  assign s_prod = prod;
  assign s_beat = beat;
  assign s_seed = seed;
  assign s_last = last;
`endif

  logic signed [M_WIDTH-1:0] ext;
  logic signed [M_WIDTH-1:0] acc;
  logic signed [M_WIDTH-1:0] sum;

  assign ext = M_WIDTH'(s_prod);
  assign sum = s_seed ? ext : acc + ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      c     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (s_beat) begin
        acc <= sum;
        if (s_last) begin
          c     <= sum;
          valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mac_array.sv
// rtl/mac_array.sv - N-lane signed MAC array returning one row of dot products.
// MAC_ARRAY_PIPE_EN selects the two-cycle pipelined lanes.
module mac_array
  import mac_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  mac_array_if.slave  bus
);
  localparam int M_WIDTH = m_width(N, WIDTH);
  localparam int CW      = cnt_width(N);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                seed;
  logic                last;
  logic [N*M_WIDTH-1:0] c_all;
  logic [N-1:0]        valid_all;

  assign seed = (state == IDLE);
  assign last = bus.sof && (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.sof) begin
      if (last) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= ACCUM;
        cnt   <= cnt + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mac_lane #(
      .WIDTH   (WIDTH),
      .M_WIDTH (M_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .beat  (bus.sof),
      .seed  (seed),
      .last  (last),
      .a     (bus.A[i*WIDTH +: WIDTH]),
      .b     (bus.B),
      .c     (c_all[i*M_WIDTH +: M_WIDTH]),
      .valid (valid_all[i])
    );
  end

  assign bus.C     = c_all;
  assign bus.valid = valid_all;
endmodule

// File: tb/tb_mac_array.sv
// tb/tb_mac_array.sv - directed self-checking bench for mac_array.
module tb_mac_array;
  localparam int N  = 6;
  localparam int W  = 16;
  localparam int MW = 37;
`ifdef MAC_ARRAY_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_array_if #(.N(N), .WIDTH(W), .M_WIDTH(MW)) bus ();

  mac_array #(.N(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  int               pulses = 0;
  int               vedge = -1, prev_vedge = -1;
  logic [N-1:0]     vval = '0;
  logic [N*MW-1:0]  vc = '0, prev_vc = '0;

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Records every valid pulse with the edge number that produced it.
  always begin
    @(posedge clk);
    #2;
    if (bus.valid !== '0) begin
      pulses++;
      prev_vedge = vedge;
      prev_vc    = vc;
      vedge      = edge_n;
      vval       = bus.valid;
      vc         = bus.C;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] lane(input logic [N*MW-1:0] c, input int i);
    return c[i*MW +: MW];
  endfunction

  int first_e, last_e;

  task automatic send_vec(input logic [N*W-1:0] a, input logic [W-1:0] b,
                          input int stall_after, input int stall_len);
    for (int i = 0; i < N; i++) begin
      bus.A = a; bus.B = b; bus.sof = 1'b1;
      tick();
      if (i == 0) first_e = edge_n;
      if (i == N - 1) last_e = edge_n;
      if (i == stall_after) begin
        bus.sof = 1'b0;
        for (int s = 0; s < stall_len; s++) tick();
      end
    end
    bus.sof = 1'b0;
  endtask

  task automatic drain();
    bus.sof = 1'b0;
    for (int i = 0; i < LAT + 2; i++) tick();
  endtask

  logic [N*W-1:0] a_ones, a_twos, a_neg, a_min;
  logic [MW-1:0]  neg36;
  int p0;

  initial begin
    for (int i = 0; i < N; i++) begin
      a_ones[i*W +: W] = 16'd1;
      a_twos[i*W +: W] = 16'd2;
      a_min[i*W +: W]  = 16'h8000;
      a_neg[i*W +: W]  = (i == 0) ? 16'hFFFD : 16'd0;
    end
    neg36 = -37'sd36;

    // Reset with beats presented: nothing may accumulate or pulse.
    rst = 1'b1; bus.sof = 1'b1;
    bus.A = {$urandom, $urandom, $urandom}; bus.B = 16'($urandom);
    tick();
    chk("rst_c0", 64'(bus.C), 64'd0);
    chk("rst_v0", 64'(bus.valid), 64'd0);
    bus.A = {$urandom, $urandom, $urandom}; bus.B = 16'($urandom);
    tick();
    chk("rst_c1", 64'(bus.C), 64'd0);
    chk("rst_v1", 64'(bus.valid), 64'd0);
    rst = 1'b0; bus.sof = 1'b0;
    tick();
    chk("rst_c_rel", 64'(bus.C), 64'd0);
    chk("rst_v_rel", 64'(bus.valid), 64'd0);
    drain();
    chk("rst_no_pulse", 64'(pulses), 64'd0);

    // Unity vector.
    p0 = pulses;
    send_vec(a_ones, 16'd1, -1, 0);
    drain();
    chk("unity_pulses", 64'(pulses - p0), 64'd1);
    chk("unity_valid", 64'(vval), 64'h3F);
    chk("unity_lat", 64'(vedge - last_e), 64'(LAT - 1));
    for (int i = 0; i < N; i++) chk($sformatf("unity_c%0d", i), 64'(lane(vc, i)), 64'd6);
    chk("unity_v_after", 64'(bus.valid), 64'd0);

    // Signed operand on lane 0.
    p0 = pulses;
    send_vec(a_neg, 16'd2, -1, 0);
    drain();
    chk("neg_pulses", 64'(pulses - p0), 64'd1);
    chk("neg_c0", 64'(lane(vc, 0)), 64'(neg36));
    chk("neg_c1", 64'(lane(vc, 1)), 64'd0);

    // Most negative operands on every lane.
    p0 = pulses;
    send_vec(a_min, 16'h8000, -1, 0);
    drain();
    chk("min_pulses", 64'(pulses - p0), 64'd1);
    chk("min_c0", 64'(lane(vc, 0)), 64'd6442450944);
    chk("min_c5", 64'(lane(vc, 5)), 64'd6442450944);

    // Three stall cycles after beat 2.
    p0 = pulses;
    send_vec(a_ones, 16'd1, 1, 3);
    drain();
    chk("stall_pulses", 64'(pulses - p0), 64'd1);
    chk("stall_c3", 64'(lane(vc, 3)), 64'd6);
    chk("stall_span", 64'(vedge - first_e), 64'(N - 1 + 3 + LAT - 1));

    // Back-to-back vectors with no gap.
    p0 = pulses;
    send_vec(a_ones, 16'd1, -1, 0);
    send_vec(a_twos, 16'd3, -1, 0);
    drain();
    chk("b2b_pulses", 64'(pulses - p0), 64'd2);
    chk("b2b_first_c", 64'(lane(prev_vc, 2)), 64'd6);
    chk("b2b_second_c", 64'(lane(vc, 2)), 64'd36);
    chk("b2b_spacing", 64'(vedge - prev_vedge), 64'd6);

    // Reset part-way through a vector.
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      bus.A = a_ones; bus.B = 16'd1; bus.sof = 1'b1;
      tick();
    end
    bus.sof = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    drain();
    chk("midrst_no_pulse", 64'(pulses - p0), 64'd0);
    chk("midrst_c_clear", 64'(bus.C), 64'd0);
    send_vec(a_ones, 16'd1, -1, 0);
    drain();
    chk("midrst_pulses", 64'(pulses - p0), 64'd1);
    chk("midrst_c", 64'(lane(vc, 4)), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
